// File: rtl/pipeline_freeze_ctrl.sv
// Freeze/flush controller for the ARM core pipeline: resolves hazard, branch and memory-wait requests.
// Optional STALL_STATS_EN macro builds saturating hazard-stall and branch-flush statistics counters.
module pipeline_freeze_ctrl #(
  parameter int unsigned WAIT_MAX = 15,
  parameter int unsigned STAT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hazard,
  input  logic              branch_taken,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              pc_freeze,
  output logic              ifid_freeze,
  output logic              ifid_flush,
  output logic              idexe_flush,
  output logic              pipe_freeze,
  output logic              mem_busy,
  output logic              mem_timeout,
  output logic [STAT_W-1:0] stall_cnt,
  output logic [STAT_W-1:0] flush_cnt
);

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_e;

  localparam logic [7:0] WAIT_MAX_C = 8'(WAIT_MAX);

  state_e     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       timeout_q, timeout_d;

  logic pc_freeze_s, ifid_freeze_s, ifid_flush_s, idexe_flush_s, pipe_freeze_s;

  // Next-state and Mealy control decode, priority: miss, branch, hazard.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    timeout_d     = timeout_q;
    pc_freeze_s   = 1'b0;
    ifid_freeze_s = 1'b0;
    ifid_flush_s  = 1'b0;
    idexe_flush_s = 1'b0;
    pipe_freeze_s = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (mem_req && !mem_ready) begin
          pc_freeze_s   = 1'b1;
          ifid_freeze_s = 1'b1;
          pipe_freeze_s = 1'b1;
          state_d       = ST_MEM_WAIT;
          wait_cnt_d    = 8'd1;
        end else if (branch_taken) begin
          ifid_flush_s  = 1'b1;
          idexe_flush_s = 1'b1;
        end else if (hazard) begin
          pc_freeze_s   = 1'b1;
          ifid_freeze_s = 1'b1;
          idexe_flush_s = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_MEM_WAIT: begin
        if (!mem_ready) begin
          pc_freeze_s   = 1'b1;
          ifid_freeze_s = 1'b1;
          pipe_freeze_s = 1'b1;
          wait_cnt_d    = (wait_cnt_q == 8'hFF) ? 8'hFF : (wait_cnt_q + 8'd1);
          if (wait_cnt_d >= WAIT_MAX_C) begin
            timeout_d = 1'b1;
          end else begin
            timeout_d = timeout_q;
          end
        end else begin
          // Release cycle: the held branch/hazard is still valid and acts now.
          state_d    = ST_RUN;
          wait_cnt_d = 8'd0;
          if (branch_taken) begin
            ifid_flush_s  = 1'b1;
            idexe_flush_s = 1'b1;
          end else if (hazard) begin
            pc_freeze_s   = 1'b1;
            ifid_freeze_s = 1'b1;
            idexe_flush_s = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = 8'd0;
      end
    endcase
  end

  // FSM, wait counter and sticky timeout registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= 8'd0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign pc_freeze   = rst & pc_freeze_s;
  assign ifid_freeze = rst & ifid_freeze_s;
  assign ifid_flush  = rst & ifid_flush_s;
  assign idexe_flush = rst & idexe_flush_s;
  assign pipe_freeze = rst & pipe_freeze_s;
  assign mem_busy    = rst & (state_q == ST_MEM_WAIT);
  assign mem_timeout = rst & timeout_q;

`ifdef STALL_STATS_EN
  logic [STAT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic              stall_evt_s, flush_evt_s;

  // A hazard stall is the only case freezing PC without freezing the whole pipe.
  assign stall_evt_s = pc_freeze_s & ~pipe_freeze_s;
  assign flush_evt_s = ifid_flush_s;

  // Saturating statistics counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= {STAT_W{1'b0}};
      flush_cnt_q <= {STAT_W{1'b0}};
    end else begin
      if (stall_evt_s && (stall_cnt_q != {STAT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + STAT_W'(1);
      end else begin
        stall_cnt_q <= stall_cnt_q;
      end
      if (flush_evt_s && (flush_cnt_q != {STAT_W{1'b1}})) begin
        flush_cnt_q <= flush_cnt_q + STAT_W'(1);
      end else begin
        flush_cnt_q <= flush_cnt_q;
      end
    end
  end

  assign stall_cnt = rst ? stall_cnt_q : {STAT_W{1'b0}};
  assign flush_cnt = rst ? flush_cnt_q : {STAT_W{1'b0}};
`else
  assign stall_cnt = {STAT_W{1'b0}};
  assign flush_cnt = {STAT_W{1'b0}};
`endif

endmodule

// File: doc/pipeline_freeze_ctrl.md
Name: pipeline_freeze_ctrl

Overview:
- Consumer side of the hazard path: takes the combinational `hazard` flag from hazard detection, `branch_taken` from the EXE stage and the MEM-stage memory handshake.
- Produces the freeze and flush controls for PC, IF/ID and ID/EXE, plus the global pipeline freeze.
- Tracks multi-cycle memory waits with an FSM and a timeout counter.
- Sits in the top-level ARM core between hazard detection, the SRAM controller and the pipeline registers.

Parameters:
- WAIT_MAX, 15: memory-wait cycles allowed before `mem_timeout` is raised (1..255).
- STAT_W, 16: width of the stall/flush statistics counters.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-low reset
- hazard  input  1  RAW hazard flag from hazard detection (combinational)
- branch_taken  input  1  EXE-stage branch resolved taken
- mem_req  input  1  MEM stage holds a load/store
- mem_ready  input  1  SRAM controller completion; valid only while mem_req=1
- pc_freeze  output  1  hold PC
- ifid_freeze  output  1  hold IF/ID register
- ifid_flush  output  1  clear IF/ID to NOP
- idexe_flush  output  1  clear ID/EXE to bubble
- pipe_freeze  output  1  hold every pipeline register (ID/EXE, EXE/MEM, MEM/WB) and PC
- mem_busy  output  1  FSM is in MEM_WAIT
- mem_timeout  output  1  sticky: a wait exceeded WAIT_MAX
- stall_cnt  output  STAT_W  hazard-stall cycles (STALL_STATS_EN only)
- flush_cnt  output  STAT_W  branch flushes (STALL_STATS_EN only)

Behaviour:
- Reset: rst is sampled on the clk edge when 0.
  - FSM goes to RUN; wait_cnt, mem_timeout and both statistics counters go to 0.
  - While rst=0, every output is forced to 0 combinationally.
  - Reset during MEM_WAIT abandons the wait; the next cycle is RUN.
- FSM states:
  - RUN: normal flow.
  - MEM_WAIT: memory access outstanding.
- Outputs are Mealy: a function of state and the current inputs. Decisions are evaluated in priority order.
- RUN, step 1, memory miss (mem_req=1, mem_ready=0):
  - pipe_freeze=pc_freeze=ifid_freeze=1, both flushes=0.
  - Next state MEM_WAIT; wait_cnt<=1.
- RUN, step 2, branch (mem_req=0 or mem_ready=1) with branch_taken=1:
  - ifid_flush=idexe_flush=1, no freezes.
  - A simultaneous hazard is ignored, because the dependent instruction is wrong-path.
- RUN, step 3, hazard only (hazard=1):
  - pc_freeze=ifid_freeze=idexe_flush=1, pipe_freeze=0.
- RUN, step 4, otherwise: all controls 0.
- A single-cycle access (mem_req=1 with mem_ready=1 in the same cycle) never enters MEM_WAIT.
- MEM_WAIT, mem_ready=0:
  - All freezes=1, flushes=0. `hazard` and `branch_taken` are ignored.
  - wait_cnt increments, saturating at 255.
  - When wait_cnt reaches WAIT_MAX, mem_timeout<=1 and stays 1 until reset. The wait continues.
- MEM_WAIT, mem_ready=1 (release cycle):
  - Freezes drop and the pipeline advances.
  - branch_taken=1: ifid_flush=idexe_flush=1. The branch stayed held in frozen ID/EXE and EXE/MEM, so it is still asserted.
  - Else hazard=1: hazard-stall controls as in RUN step 3.
  - Next state RUN; wait_cnt<=0.
- Back-to-back misses: the release cycle always returns to RUN. A new miss is detected in RUN on the following cycle.
- ifid_freeze and ifid_flush are never both 1.
- mem_busy=1 exactly when state=MEM_WAIT.

Optional Feature:
- Macro: STALL_STATS_EN.
- Defined:
  - stall_cnt increments on every cycle with hazard-stall controls active, in RUN or the release cycle.
  - flush_cnt increments on every cycle with ifid_flush=1.
  - Both saturate at all-ones and clear on reset.
- Undefined: no counter flops are built; stall_cnt and flush_cnt are tied to 0.

Test Plan:
- Reset: rst=0 for 2 cycles with hazard=1, mem_req=1, mem_ready=0 -> all outputs 0 during reset; RUN afterwards.
- Hazard only: hazard=1 for 2 cycles -> pc_freeze=ifid_freeze=idexe_flush=1 both cycles, pipe_freeze=0; stall_cnt=2 (STALL_STATS_EN).
- Branch over hazard: branch_taken=1 and hazard=1 together -> ifid_flush=idexe_flush=1, pc_freeze=0; flush_cnt=1.
- Memory wait with pending branch: mem_req=1, mem_ready=0 for 4 cycles with branch_taken=1, then mem_ready=1:
  - pipe_freeze=1 and mem_busy=1 for 4 cycles, flushes 0.
  - Release cycle: freezes 0, ifid_flush=idexe_flush=1, state back to RUN.
- Timeout: WAIT_MAX=3, mem_ready held 0 for 5 cycles -> mem_timeout rises at the 3rd wait cycle, stays 1 after release, clears only on rst=0.
- Reset mid-wait: rst=0 in the 2nd MEM_WAIT cycle -> next cycle state=RUN, mem_busy=0, wait_cnt=0; mem_ready=1 arriving later alone does not cause a freeze.
